// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI slave-port arbiter.
// Optional watchdog macro used by the arbiter: AXI_ARB_WDOG_EN.
package axi_arb_pkg;

    localparam int unsigned NUM_MST_MAX = 8;
    localparam int unsigned IDX_MAX_W   = $clog2(NUM_MST_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StBresp,
        StRaddr,
        StRdata
    } state_e;

    function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [NUM_MST_MAX-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NUM_MST_MAX); i++) begin
            if (oh[i]) idx |= IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_slv_arbiter_if.sv
// Request, snooped slave handshake and grant signals of the AXI slave-port arbiter.
// master modport is the arbiter side; slave modport is the mux/master environment side.
interface axi_slv_arbiter_if #(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_MST)
);
    logic [NUM_MST-1:0] m_awvalid;
    logic [NUM_MST-1:0] m_arvalid;
    logic               s_awvalid, s_awready;
    logic               s_wvalid, s_wready, s_wlast;
    logic               s_bvalid, s_bready;
    logic               s_arvalid, s_arready;
    logic               s_rvalid, s_rready, s_rlast;
    logic [NUM_MST-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_wr;
    logic               gnt_rd;
    logic               busy;
    logic               err_timeout;

    modport master (
        input  m_awvalid, m_arvalid,
        input  s_awvalid, s_awready, s_wvalid, s_wready, s_wlast,
        input  s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast,
        output gnt, gnt_idx, gnt_wr, gnt_rd, busy, err_timeout
    );

    modport slave (
        output m_awvalid, m_arvalid,
        output s_awvalid, s_awready, s_wvalid, s_wready, s_wlast,
        output s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast,
        input  gnt, gnt_idx, gnt_wr, gnt_rd, busy, err_timeout
    );

endinterface

// File: rtl/axi_slv_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after rr_ptr (wrapping) wins.
module rr_picker
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_MST-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    int   pos;
    logic found;

    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        pos    = 0;
        // Search starts one past the last winner so the last winner ranks lowest.
        for (int i = 1; i <= int'(NUM_MST); i++) begin
            pos = (int'(rr_ptr) + i) % int'(NUM_MST);
            if (!found && req[pos]) begin
                win_oh[pos] = 1'b1;
                found       = 1'b1;
            end
        end
        win_idx = IDX_W'(onehot2idx(NUM_MST_MAX'(win_oh)));
    end

endmodule

// File: rtl/axi_slv_arbiter.sv
// Grants one AXI slave port to one of NUM_MST masters per whole transaction.
// Optional stall watchdog compiled in with AXI_ARB_WDOG_EN.
module axi_slv_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MST     = 2,
    parameter int unsigned IDX_W       = $clog2(NUM_MST),
    parameter int unsigned WDOG_CYCLES = 256
) (
    input logic                 aclk,
    input logic                 areset_n,
    axi_slv_arbiter_if.master   bus
);

    state_e             state_q;
    logic [NUM_MST-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_wr_q;
    logic               gnt_rd_q;
    logic               busy_q;
    logic [IDX_W-1:0]   rr_ptr_q;

    logic [NUM_MST-1:0] req;
    logic [NUM_MST-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic               txn_done;
    logic               wdog_expire;

    assign req   = bus.m_awvalid | bus.m_arvalid;
    assign aw_hs = bus.s_awvalid & bus.s_awready;
    assign w_hs  = bus.s_wvalid & bus.s_wready;
    assign b_hs  = bus.s_bvalid & bus.s_bready;
    assign ar_hs = bus.s_arvalid & bus.s_arready;
    assign r_hs  = bus.s_rvalid & bus.s_rready;

    rr_picker #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign txn_done = ((state_q == StBresp) && b_hs) ||
                      ((state_q == StRdata) && r_hs && bus.s_rlast) ||
                      wdog_expire;

`ifdef AXI_ARB_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_q;
    logic              progress;
    logic              err_q;

    assign progress = ((state_q == StWaddr) && aw_hs) || ((state_q == StWdata) && w_hs) ||
                      ((state_q == StBresp) && b_hs)  || ((state_q == StRaddr) && ar_hs) ||
                      ((state_q == StRdata) && r_hs);

    assign wdog_expire = busy_q && !progress && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wdog_expire;
            if (state_q == StIdle || progress || wdog_expire) wdog_q <= '0;
            else                                             wdog_q <= wdog_q + 1'b1;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign wdog_expire     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_wr_q  <= 1'b0;
            gnt_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            rr_ptr_q  <= IDX_W'(NUM_MST - 1);
        end else if (txn_done) begin
            // Completion or watchdog abort; rr_ptr keeps the last winner.
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_wr_q  <= 1'b0;
            gnt_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        gnt_q     <= win_oh;
                        gnt_idx_q <= win_idx;
                        rr_ptr_q  <= win_idx;
                        busy_q    <= 1'b1;
                        if (bus.m_awvalid[win_idx]) begin
                            state_q  <= StWaddr;
                            gnt_wr_q <= 1'b1;
                        end else begin
                            state_q  <= StRaddr;
                            gnt_rd_q <= 1'b1;
                        end
                    end
                end
                StWaddr: if (aw_hs)                state_q <= StWdata;
                StWdata: if (w_hs && bus.s_wlast)  state_q <= StBresp;
                StRaddr: if (ar_hs)                state_q <= StRdata;
                StBresp, StRdata: ;
                default: begin
                    state_q   <= StIdle;
                    gnt_q     <= '0;
                    gnt_idx_q <= '0;
                    gnt_wr_q  <= 1'b0;
                    gnt_rd_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_wr  = gnt_wr_q;
    assign bus.gnt_rd  = gnt_rd_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_axi_slv_arbiter.sv
// Directed bench for axi_slv_arbiter with two masters; watchdog checks follow AXI_ARB_WDOG_EN.
module tb_axi_slv_arbiter;
    import axi_arb_pkg::*;

    typedef enum logic [2:0] {HsNone, HsAw, HsW, HsWl, HsB, HsAr, HsR, HsRl} hs_e;

    // exp = {gnt[1:0], gnt_idx, gnt_wr, gnt_rd, busy, err_timeout}
    typedef struct {
        logic       rst;
        logic [1:0] aw;
        logic [1:0] ar;
        hs_e        hs;
        logic [6:0] exp;
    } vec_t;

    logic aclk;
    logic areset_n;
    int   tests;
    int   fails;
    vec_t vecs[$];

    axi_slv_arbiter_if #(.NUM_MST(2), .IDX_W(1)) bus ();

    axi_slv_arbiter #(
        .NUM_MST     (2),
        .IDX_W       (1),
        .WDOG_CYCLES (16)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [6:0] snap();
        return {bus.gnt, bus.gnt_idx, bus.gnt_wr, bus.gnt_rd, bus.busy, bus.err_timeout};
    endfunction

    function automatic logic [6:0] mk(input logic [1:0] g, input logic i, input logic w,
                                      input logic r, input logic b, input logic e);
        return {g, i, w, r, b, e};
    endfunction

    task automatic chk(input string name, input int n, input logic [6:0] got,
                       input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s #%0d got {gnt,idx,wr,rd,busy,err}=%b expected %b", name, n, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] aw, input logic [1:0] ar,
                       input hs_e hs, input logic [1:0] g, input logic i, input logic w,
                       input logic r, input logic b);
        vec_t v;
        v.rst = rst;
        v.aw  = aw;
        v.ar  = ar;
        v.hs  = hs;
        v.exp = mk(g, i, w, r, b, 1'b0);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] aw, input logic [1:0] ar, input hs_e hs);
        bus.m_awvalid = aw;
        bus.m_arvalid = ar;
        {bus.s_awvalid, bus.s_awready, bus.s_wvalid, bus.s_wready, bus.s_wlast} = '0;
        {bus.s_bvalid, bus.s_bready, bus.s_arvalid, bus.s_arready} = '0;
        {bus.s_rvalid, bus.s_rready, bus.s_rlast} = '0;
        case (hs)
            HsAw: {bus.s_awvalid, bus.s_awready} = 2'b11;
            HsW:  {bus.s_wvalid, bus.s_wready} = 2'b11;
            HsWl: {bus.s_wvalid, bus.s_wready, bus.s_wlast} = 3'b111;
            HsB:  {bus.s_bvalid, bus.s_bready} = 2'b11;
            HsAr: {bus.s_arvalid, bus.s_arready} = 2'b11;
            HsR:  {bus.s_rvalid, bus.s_rready} = 2'b11;
            HsRl: {bus.s_rvalid, bus.s_rready, bus.s_rlast} = 3'b111;
            default: ;
        endcase
    endtask

    task automatic step(input logic [1:0] aw, input logic [1:0] ar, input hs_e hs);
        drive(aw, ar, hs);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, HsNone);
        areset_n = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Single read by master 0, four R beats.
        add(1, 2'b00, 2'b01, HsNone, 2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b01, HsAr,   2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsR,    2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsR,    2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsR,    2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsRl,   2'b00, 0, 0, 0, 0);
        // Both masters writing continuously: grants alternate with an idle gap.
        for (int t = 0; t < 4; t++) begin
            logic       w;
            logic [1:0] g;
            w = logic'(t % 2);
            g = w ? 2'b10 : 2'b01;
            add(t == 0, 2'b11, 2'b00, HsNone, g, w, 1, 0, 1);
            add(0,      2'b11, 2'b00, HsAw,   g, w, 1, 0, 1);
            add(0,      2'b11, 2'b00, HsWl,   g, w, 1, 0, 1);
            add(0,      2'b11, 2'b00, HsB,    2'b00, 0, 0, 0, 0);
        end
        // Stray handshake in idle, then stray B/W handshakes during a read.
        add(0, 2'b00, 2'b00, HsRl,   2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b01, HsNone, 2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b01, HsAr,   2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsB,    2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsR,    2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsWl,   2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsRl,   2'b00, 0, 0, 0, 0);
        // rr_ptr=0: master 1 write+read wins as write, then master 0 read, then master 1 read.
        add(0, 2'b10, 2'b11, HsNone, 2'b10, 1, 1, 0, 1);
        add(0, 2'b10, 2'b11, HsAw,   2'b10, 1, 1, 0, 1);
        add(0, 2'b00, 2'b11, HsWl,   2'b10, 1, 1, 0, 1);
        add(0, 2'b00, 2'b11, HsB,    2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b11, HsNone, 2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b11, HsAr,   2'b01, 0, 0, 1, 1);
        add(0, 2'b00, 2'b10, HsRl,   2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b10, HsNone, 2'b10, 1, 0, 1, 1);
        add(0, 2'b00, 2'b10, HsAr,   2'b10, 1, 0, 1, 1);
        add(0, 2'b00, 2'b00, HsRl,   2'b00, 0, 0, 0, 0);

        areset_n = 1'b1;
        drive(2'b00, 2'b00, HsNone);
        #2 areset_n = 1'b0;
        #1 chk("reset_state", 0, snap(), 7'b0);
        do_reset();
        chk("after_reset_release", 0, snap(), 7'b0);

        foreach (vecs[n]) begin
            if (vecs[n].rst) do_reset();
            step(vecs[n].aw, vecs[n].ar, vecs[n].hs);
            chk("vector", n, snap(), vecs[n].exp);
        end

        // Asynchronous reset during the second of four W beats.
        do_reset();
        step(2'b01, 2'b00, HsNone);
        chk("wr_grant", 0, snap(), mk(2'b01, 0, 1, 0, 1, 0));
        step(2'b01, 2'b00, HsAw);
        step(2'b00, 2'b00, HsW);
        drive(2'b00, 2'b00, HsW);
        #3 areset_n = 1'b0;
        #1 chk("async_reset", 0, snap(), 7'b0);
        drive(2'b00, 2'b00, HsNone);
        @(posedge aclk);
        #1 areset_n = 1'b1;
        step(2'b11, 2'b00, HsNone);
        chk("grant_after_reset", 0, snap(), mk(2'b01, 0, 1, 0, 1, 0));

        // Master 0 drops its valid and the slave never accepts the address.
        do_reset();
        step(2'b01, 2'b00, HsNone);
        chk("stall_grant", 0, snap(), mk(2'b01, 0, 1, 0, 1, 0));
        for (int k = 1; k <= 30; k++) begin
            logic [6:0] e;
            step(2'b00, 2'b00, HsNone);
`ifdef AXI_ARB_WDOG_EN
            if (k < 16)       e = mk(2'b01, 0, 1, 0, 1, 0);
            else if (k == 16) e = mk(2'b00, 0, 0, 0, 0, 1);
            else              e = 7'b0;
`else
            e = mk(2'b01, 0, 1, 0, 1, 0);
`endif
            chk("stall_hold", k, snap(), e);
        end
`ifndef AXI_ARB_WDOG_EN
        step(2'b00, 2'b00, HsAw);
        step(2'b00, 2'b00, HsWl);
        step(2'b00, 2'b00, HsB);
        chk("stall_complete", 0, snap(), 7'b0);
`endif
        step(2'b11, 2'b00, HsNone);
        chk("rr_after_stall", 0, snap(), mk(2'b10, 1, 1, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_slv_arbiter.md
Name: axi_slv_arbiter

Overview:
- Scheduler that shares one AXI slave wrapper port between NUM_MST masters.
- Each transaction (AW+W+B or AR+R) is granted atomically to one master. The grant is held until the transaction's final handshake.
- Controls an external combinational AXI mux through one-hot grant outputs and snoops the muxed slave-side handshakes to track progress.
- Matches the slave's one-transaction-at-a-time sequencing: write, then response, or read, then data.

Parameters:
- NUM_MST, 2, number of requesting masters (2..8).
- IDX_W, $clog2(NUM_MST), width of the grant index.
- WDOG_CYCLES, 256, stall limit in cycles for the watchdog (used only when the optional feature is compiled in).

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- m_awvalid  in  NUM_MST  per-master AW request
- m_arvalid  in  NUM_MST  per-master AR request
- s_awvalid, s_awready  in  1 each  muxed AW handshake at slave
- s_wvalid, s_wready, s_wlast  in  1 each  muxed W handshake at slave
- s_bvalid, s_bready  in  1 each  muxed B handshake at slave
- s_arvalid, s_arready  in  1 each  muxed AR handshake at slave
- s_rvalid, s_rready, s_rlast  in  1 each  muxed R handshake at slave
- gnt  out  NUM_MST  one-hot grant (mux select and valid gate)
- gnt_idx  out  IDX_W  binary index of the granted master (prefix for the slave ID)
- gnt_wr  out  1  granted transaction is a write
- gnt_rd  out  1  granted transaction is a read
- busy  out  1  state != IDLE
- err_timeout  out  1  watchdog abort pulse (only with the feature)

Behaviour:
- Clock is aclk. Reset is asynchronous, active-low on areset_n.
- Reset values: state=IDLE, gnt=0, gnt_idx=0, gnt_wr=0, gnt_rd=0, busy=0, err_timeout=0, rr_ptr=NUM_MST-1 (so master 0 wins first). All outputs are registered.
- States: IDLE, WADDR, WDATA, BRESP, RADDR, RDATA.
- IDLE:
  - If any m_awvalid or m_arvalid bit is set, pick a winner round-robin, starting at rr_ptr+1 mod NUM_MST.
  - Winner with m_awvalid set goes to WADDR (gnt_wr=1). Otherwise it goes to RADDR (gnt_rd=1). Write has priority within one master.
  - gnt, gnt_idx and rr_ptr are loaded on the same edge.
  - Latency from request to gnt is 1 cycle.
- Transitions:
  - WADDR to WDATA on s_awvalid&s_awready.
  - WDATA to BRESP on s_wvalid&s_wready&s_wlast.
  - BRESP to IDLE on s_bvalid&s_bready.
  - RADDR to RDATA on s_arvalid&s_arready.
  - RDATA to IDLE on s_rvalid&s_rready&s_rlast.
  - Completion ignores the response code.
- Grant lifetime:
  - gnt, gnt_idx, gnt_wr and gnt_rd stay constant for the whole transaction.
  - All are cleared on the edge that enters IDLE.
  - There is at least one IDLE cycle with gnt=0 between transactions; back-to-back grants are never issued.
- Fairness:
  - rr_ptr updates only on grant.
  - With all masters requesting continuously, grants rotate 0,1,...,NUM_MST-1.
- Requests from non-granted masters are ignored while busy. They must hold valid until granted, per AXI.
- A granted master dropping its valid mid-transaction is a protocol violation. The FSM holds its state (recovery only via the watchdog).
- Simultaneous s_* handshakes outside the current state are ignored; e.g. s_rvalid in WDATA.
- Asserting areset_n low mid-transaction immediately clears gnt and returns to IDLE. No completion is issued.

Optional Feature:
- Macro: AXI_ARB_WDOG_EN.
- With it:
  - A stall counter, $clog2(WDOG_CYCLES)+1 bits wide, clears on every progress handshake and on IDLE, and increments otherwise while busy.
  - When it reaches WDOG_CYCLES-1, the FSM is forced to IDLE, gnt is cleared, and err_timeout pulses high for 1 cycle.
  - rr_ptr keeps the aborted master's index.
- Without it: no counter is built, err_timeout is tied to 0, and a stalled transaction holds the grant indefinitely.

Decomposition:
- Package axi_arb_pkg holds:
  - the state_e enum (3 bits);
  - localparam NUM_MST_MAX=8;
  - a function onehot2idx().
- The AXI widths stay in the existing AXI define include.
- One sub-module: rr_picker. It is combinational: inputs are the req vector and rr_ptr; outputs are the one-hot winner and its index.
- The FSM, grant registers and watchdog live in axi_slv_arbiter.

Test Plan:
1. Reset, then m_arvalid=2'b01, AR handshake, 4 R beats with rlast on beat 4.
   - gnt=01 and gnt_rd=1 one cycle after the request.
   - gnt=00 the cycle after the rlast handshake.
2. m_awvalid=2'b11 held continuously for 4 transactions of 1-beat write plus B.
   - Grants go 01,10,01,10, each separated by one gnt=00 cycle.
3. Master 1 asserts m_awvalid and m_arvalid together with m_arvalid[0]=1, rr_ptr=0.
   - Master 1 wins with gnt_wr=1; master 0's read is granted next.
4. Assert areset_n=0 during WDATA on beat 2 of 4.
   - gnt=00, busy=0 asynchronously; the next request is granted to master 0.
5. AXI_ARB_WDOG_EN, WDOG_CYCLES=16, RADDR with s_arready held 0.
   - err_timeout is high for exactly 1 cycle, 16 cycles after the grant; the FSM returns to IDLE.
6. s_bvalid pulses while in RDATA.
   - No state change; the read completes normally on rlast.
